fetch_decode: RTL
=================

Name: fetch_decode

Overview:
Instruction fetch and decode stage that feeds the ALU/CPU execute stage.
- Owns the program counter and issues word reads to instruction RAM over a valid/ready request port.
- Buffers returned instruction words in a small in-order queue.
- Presents the decoded R/I/J fields (opcode, rs, rt, rd, shamt, funct, imm, addr) to execute through a valid/ready handshake.
- Execute drives redirect on a taken beq or a jump.

Parameters:
ADDR_W, 12, word-address width of instruction RAM (4096 words); PC wraps modulo 2^ADDR_W.
DEPTH, 2, instruction queue depth; also the cap on requests in flight plus queued words.

Ports:
clk  in  1  single clock; all state updates on posedge clk
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  read request valid
imem_req_addr  out  ADDR_W  word address to read (current fetch PC)
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  read data valid; responses return in order, latency >= 1 cycle
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  execute-stage branch/jump taken
redirect_pc  in  ADDR_W  new fetch address
dec_valid  out  1  decoded instruction available
dec_ready  in  1  execute consumes instruction
dec_pc  out  ADDR_W  address of presented instruction
dec_opcode  out  6  bits [31:26]
dec_rs  out  5  bits [25:21]
dec_rt  out  5  bits [20:16]
dec_rd  out  5  bits [15:11]
dec_shamt  out  5  bits [10:6]
dec_funct  out  6  bits [5:0]
dec_imm  out  16  bits [15:0]
dec_addr  out  26  bits [25:0]
dec_illegal  out  1  opcode not in {0x00, 0x0F, 0x23, 0x2B, 0x04, 0x02}

Behaviour:
- Reset, while rst is high:
  - fetch_pc=0, queue empty, outstanding=0, drop_cnt=0.
  - imem_req_valid=0, dec_valid=0, all dec_* fields 0.
  - Reset mid-operation discards all queued and in-flight state; responses to requests issued before reset are ignored via drop_cnt=0 plus the memory being reset together with this block.
- Request issue:
  - imem_req_valid = !rst && (outstanding + count < DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On request accept (valid && ready): fetch_pc <= fetch_pc + 1, wrapping 2^ADDR_W-1 -> 0; outstanding += 1.
- Response handling:
  - On imem_rsp_valid, outstanding -= 1.
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise push {data, pc} into the queue. The pc is tracked by a resp_pc counter that advances per non-dropped response.
  - No overflow is possible because of the credit rule.
- Output:
  - dec_valid = queue not empty.
  - dec_* fields are combinational slices of the queue-head word; dec_pc is the head pc.
  - Pop on dec_valid && dec_ready.
  - Push and pop in the same cycle are allowed, including when the queue is full (pop frees the slot first).
  - An empty-queue push is visible one cycle later (registered queue). Minimum fetch-to-dec_valid latency is memory latency + 1.
- Decode is field extraction only. Illegal opcodes are still delivered with dec_illegal=1; execute decides what to do with them.
- Redirect (highest priority):
  - Queue flushed, so dec_valid=0 next cycle.
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc.
  - drop_cnt <= outstanding_next, i.e. including a request accepted this cycle and excluding a response arriving this cycle.
  - Requests are suppressed in the redirect cycle.
  - A pop in the same cycle is still honoured: execute owns that instruction.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Counter widths: outstanding, count and drop_cnt are $clog2(DEPTH+1) bits.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants OP_RTYPE=6'h00, OP_LI=6'h0F, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02.
  - Instruction field bit-position localparams.
  - Packed struct instr_t {opcode, rs, rt, rd, shamt, funct}.
- Sub-module: sync_fifo (parameterised width/depth; synchronous flush; count output) for the instruction queue.

Test Plan:
- Reset then a 1-cycle-latency, always-ready memory holding ram[0]=0x00221820, ram[1]=0x3C010005 -> first dec_valid with dec_pc=0, rs=1, rt=2, rd=3, funct=0x20, illegal=0; next dec_pc=1, opcode=0x0F, imm=0x0005.
- dec_ready held low for 10 cycles -> at most DEPTH=2 requests issued, queue full, no further imem_req_valid; release ready -> pcs 0,1,2,... delivered in order with no gaps or duplicates.
- Memory latency 3 with 2 requests in flight, then redirect_valid with redirect_pc=0x100 -> both stale responses dropped; next dec_pc=0x100.
- Redirect in the same cycle a request is accepted and a response returns -> drop_cnt correct; no stale word ever presented.
- fetch_pc=0xFFF -> following request address 0x000.
- ram word 0xFC000000 -> dec_illegal=1, delivered normally.
- rst asserted while 2 requests are in flight and the queue is full -> next cycle dec_valid=0, imem_req_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared instruction-set definitions for the fetch/decode and execute stages:
// opcodes, field bit positions, the R-type field struct and an opcode legality check.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LI    = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int RT_HI     = 20;
   localparam int RT_LO     = 16;
   localparam int RD_HI     = 15;
   localparam int RD_LO     = 11;
   localparam int SHAMT_HI  = 10;
   localparam int SHAMT_LO  = 6;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;
   localparam int IMM_HI    = 15;
   localparam int IMM_LO    = 0;
   localparam int ADDR_HI   = 25;
   localparam int ADDR_LO   = 0;

   // Field widths follow the bit positions so the struct overlays a 32-bit word exactly.
   typedef struct packed {
      logic [OPCODE_HI-OPCODE_LO:0] opcode;
      logic [RS_HI-RS_LO:0]         rs;
      logic [RT_HI-RT_LO:0]         rt;
      logic [RD_HI-RD_LO:0]         rd;
      logic [SHAMT_HI-SHAMT_LO:0]   shamt;
      logic [FUNCT_HI-FUNCT_LO:0]   funct;
   } instr_t;

   function automatic logic opcode_illegal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b0;
         default:                                     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered in-order queue with synchronous flush and occupancy count.
// A pop frees its slot first, so push and pop together are accepted even when full.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries data only; occupancy is governed by the pointers above.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch and decode: owns the fetch PC, issues credit-limited reads to
// instruction RAM, queues returned words and presents decoded fields to execute.
module fetch_decode
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [5:0]        dec_opcode,
   output logic [4:0]        dec_rs,
   output logic [4:0]        dec_rt,
   output logic [4:0]        dec_rd,
   output logic [4:0]        dec_shamt,
   output logic [5:0]        dec_funct,
   output logic [15:0]       dec_imm,
   output logic [25:0]       dec_addr,
   output logic              dec_illegal
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int QW = 32 + ADDR_W;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     outstanding_next;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     count;
   logic              empty;
   logic              credit_ok;
   logic              req_fire;
   logic              push;
   logic              pop;
   logic [QW-1:0]     head;
   logic [ADDR_W-1:0] head_pc;
   logic [31:0]       head_word;
   logic [31:0]       dec_word;
   instr_t            dec_instr;

   // Words in flight plus words queued never exceed DEPTH, so the queue cannot overflow.
   assign credit_ok        = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(DEPTH);
   assign imem_req_valid   = !rst && credit_ok && !redirect_valid;
   assign imem_req_addr    = fetch_pc;
   assign req_fire         = imem_req_valid && imem_req_ready;
   assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
   assign push             = imem_rsp_valid && (drop_cnt == '0);
   assign pop              = dec_valid && dec_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= '0;
         resp_pc     <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            // Every request still owed a response at this point fetched down the old path.
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop_cnt <= outstanding_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(1);
            if (imem_rsp_valid) begin
               if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
               else                resp_pc  <= resp_pc + ADDR_W'(1);
            end
         end
      end
   end

   sync_fifo #(
      .WIDTH (QW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({resp_pc, imem_rsp_data}),
      .pop       (pop),
      .pop_data  (head),
      .count     (count),
      .empty     (empty)
   );

   assign {head_pc, head_word} = head;

   // Fields read as zero whenever nothing is presented, including during reset.
   assign dec_valid   = !rst && !empty;
   assign dec_word    = dec_valid ? head_word : '0;
   assign dec_pc      = dec_valid ? head_pc : '0;
   assign dec_instr   = instr_t'(dec_word);
   assign dec_opcode  = dec_instr.opcode;
   assign dec_rs      = dec_instr.rs;
   assign dec_rt      = dec_instr.rt;
   assign dec_rd      = dec_instr.rd;
   assign dec_shamt   = dec_instr.shamt;
   assign dec_funct   = dec_instr.funct;
   assign dec_imm     = dec_word[IMM_HI:IMM_LO];
   assign dec_addr    = dec_word[ADDR_HI:ADDR_LO];
   assign dec_illegal = dec_valid && opcode_illegal(dec_instr.opcode);

endmodule
